// File: rtl/comm_calib_pkg.sv
// Shared types and constants for the comm link delay calibration controller.
package comm_calib_pkg;

  localparam int unsigned IDX_W     = 4;
  // Galois taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] PRBS_POLY = 32'h0040_0007;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_MEASURE,
    ST_EVAL,
    ST_LOCK,
    ST_DONE
  } calib_state_t;

endpackage

// File: rtl/comm_delay_calib_if.sv
// User/comm stream handshake bundle seen by the calibration arbiter.
interface comm_delay_calib_if;
  logic        usr_valid_i;
  logic [31:0] usr_data_i;
  logic        usr_ack_i;
  logic        usr_valid_o;
  logic [31:0] usr_data_o;
  logic        usr_ack_o;
  logic        comm_valid_i;
  logic [31:0] comm_data_i;
  logic        comm_ack_i;
  logic        comm_valid_o;
  logic [31:0] comm_data_o;
  logic        comm_ack_o;

  modport master (
    input  usr_valid_i, usr_data_i, usr_ack_o,
    input  comm_ack_i, comm_valid_o, comm_data_o,
    output usr_ack_i, usr_valid_o, usr_data_o,
    output comm_valid_i, comm_data_i, comm_ack_o
  );

  modport slave (
    output usr_valid_i, usr_data_i, usr_ack_o,
    output comm_ack_i, comm_valid_o, comm_data_o,
    input  usr_ack_i, usr_valid_o, usr_data_o,
    input  comm_valid_i, comm_data_i, comm_ack_o
  );
endinterface

// File: rtl/comm_calib_prbs32.sv
// Seeded 32-bit Galois LFSR; advances one step per enabled cycle.
module comm_calib_prbs32
  import comm_calib_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_adv,
    output logic [31:0] o_lfsr
);

    logic [31:0] r_lfsr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= SEED;
        end else if (i_adv) begin
            r_lfsr <= {r_lfsr[30:0], 1'b0} ^ (r_lfsr[31] ? PRBS_POLY : '0);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/comm_delay_calib.sv
// Sweeps valid/sample delays under PRBS traffic, scores each point on the raw
// compare stream, locks the best one, and otherwise passes user traffic through.
module comm_delay_calib
  import comm_calib_pkg::*;
#(
    parameter int unsigned NSAMP     = 256,
    parameter int unsigned SETTLE    = 64,
    parameter int unsigned TIMEOUT   = 4096,
    parameter int unsigned ERRW      = 16,
    parameter logic [31:0] PRBS_SEED = 32'h0000_0001
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [ERRW-1:0]     best_err,
    output logic [IDX_W-1:0]    ad1_delay,
    output logic [IDX_W-1:0]    ad2_delay,
    output logic [IDX_W-1:0]    ad_valid_delay,
    input  logic                valid_raw,
    input  logic [7:0]          raw_send_d,
    input  logic [7:0]          raw_recv,
    comm_delay_calib_if.master  bus
);

    calib_state_t       r_state, w_next;
    logic [31:0]        r_cnt, r_samp, r_tmo;
    logic [ERRW-1:0]    r_err, r_best_err;
    logic [IDX_W-1:0]   r_v, r_s, r_rec_v, r_rec_s, r_vdly, r_sdly;
    logic               r_fail, r_done;
    logic               w_busy, w_mism, w_samp_hit, w_tmo_hit, w_last_pt, w_lfsr_adv;
    logic [31:0]        w_lfsr;
    logic               w_unused_raw;

    assign w_busy       = r_state inside {ST_APPLY, ST_SETTLE, ST_MEASURE, ST_EVAL, ST_LOCK};
    assign w_mism       = raw_send_d[5:0] != raw_recv[5:0];
    assign w_samp_hit   = valid_raw && (r_samp == NSAMP - 1);
    assign w_tmo_hit    = r_tmo == TIMEOUT - 1;
    assign w_last_pt    = (r_v == '1) && (r_s == '1);
    assign w_lfsr_adv   = w_busy && bus.comm_ack_i;
    assign w_unused_raw = ^{raw_send_d[7:6], raw_recv[7:6]};

    comm_calib_prbs32 #(.SEED(PRBS_SEED)) u_prbs (
        .i_clk  (CLK),
        .i_rst  (RST),
        .i_adv  (w_lfsr_adv),
        .o_lfsr (w_lfsr)
    );

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: if (start) w_next = ST_APPLY;
            ST_APPLY:         w_next = ST_SETTLE;
            ST_SETTLE:        if (r_cnt == SETTLE - 1) w_next = ST_MEASURE;
            ST_MEASURE:       if (w_samp_hit || w_tmo_hit) w_next = ST_EVAL;
            ST_EVAL:          w_next = w_last_pt ? ST_LOCK : ST_APPLY;
            ST_LOCK:          w_next = ST_DONE;
            default:          w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_v        <= '0;
            r_s        <= '0;
            r_rec_v    <= '0;
            r_rec_s    <= '0;
            r_vdly     <= '0;
            r_sdly     <= '0;
            r_cnt      <= '0;
            r_samp     <= '0;
            r_tmo      <= '0;
            r_err      <= '0;
            r_best_err <= '0;
            r_fail     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == ST_LOCK);
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_v        <= '0;
                        r_s        <= '0;
                        r_rec_v    <= '0;
                        r_rec_s    <= '0;
                        r_best_err <= '1;
                        r_fail     <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    r_vdly <= r_v;
                    r_sdly <= r_s;
                    r_cnt  <= '0;
                    r_samp <= '0;
                    r_tmo  <= '0;
                    r_err  <= '0;
                end
                ST_SETTLE: r_cnt <= r_cnt + 32'd1;
                ST_MEASURE: begin
                    r_tmo <= r_tmo + 32'd1;
                    if (valid_raw) begin
                        r_samp <= r_samp + 32'd1;
                        if (w_mism && (r_err != '1)) r_err <= r_err + ERRW'(1);
                    end
                    // A sample that completes the point beats a coincident timeout
                    if (w_tmo_hit && !w_samp_hit) r_err <= '1;
                end
                ST_EVAL: begin
                    if (r_err < r_best_err) begin
                        r_best_err <= r_err;
                        r_rec_v    <= r_v;
                        r_rec_s    <= r_s;
                    end
                    r_s <= r_s + IDX_W'(1);
                    if (r_s == '1) r_v <= r_v + IDX_W'(1);
                end
                ST_LOCK: begin
                    r_vdly <= r_rec_v;
                    r_sdly <= r_rec_s;
                    r_fail <= (r_best_err != '0);
                end
                default: ;
            endcase
        end
    end

    // PRBS owns the link while busy; RX beats are acked and dropped
    always_comb begin
        if (w_busy) begin
            bus.comm_valid_i = 1'b1;
            bus.comm_data_i  = w_lfsr;
            bus.usr_ack_i    = 1'b0;
            bus.usr_valid_o  = 1'b0;
            bus.usr_data_o   = bus.comm_data_o;
            bus.comm_ack_o   = 1'b1;
        end else begin
            bus.comm_valid_i = bus.usr_valid_i;
            bus.comm_data_i  = bus.usr_data_i;
            bus.usr_ack_i    = bus.comm_ack_i;
            bus.usr_valid_o  = bus.comm_valid_o;
            bus.usr_data_o   = bus.comm_data_o;
            bus.comm_ack_o   = bus.usr_ack_o;
        end
    end

    assign busy           = w_busy;
    assign done           = r_done;
    assign fail           = r_fail;
    assign best_err       = r_best_err;
    assign ad_valid_delay = r_vdly;
    assign ad1_delay      = r_sdly;
    assign ad2_delay      = r_sdly;

endmodule

// File: tb/tb_comm_delay_calib.sv
// Directed bench: zero-latency loopback model with per-point corruption patterns.
module tb_comm_delay_calib;

    localparam int unsigned T_NSAMP   = 8;
    localparam int unsigned T_SETTLE  = 4;
    localparam int unsigned T_TIMEOUT = 16;
    localparam int          BUDGET    = 256 * (T_SETTLE + T_TIMEOUT + 4) + 64;

    logic        CLK = 1'b0;
    logic        RST, start;
    logic        busy, done, fail;
    logic [15:0] best_err;
    logic [3:0]  ad1_delay, ad2_delay, ad_valid_delay;
    logic        valid_raw;
    logic [7:0]  raw_send_d, raw_recv, corrupt;
    logic [7:0]  tick = '0;
    int          mode = 1;
    int          n_chk = 0, n_err = 0;
    logic        ref_en = 1'b0;
    logic        ref_adv;
    logic [31:0] ref_lfsr;

    comm_delay_calib_if ifc ();

    comm_delay_calib #(
        .NSAMP    (T_NSAMP),
        .SETTLE   (T_SETTLE),
        .TIMEOUT  (T_TIMEOUT),
        .ERRW     (16),
        .PRBS_SEED(32'h0000_0001)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .fail          (fail),
        .best_err      (best_err),
        .ad1_delay     (ad1_delay),
        .ad2_delay     (ad2_delay),
        .ad_valid_delay(ad_valid_delay),
        .valid_raw     (valid_raw),
        .raw_send_d    (raw_send_d),
        .raw_recv      (raw_recv),
        .bus           (ifc)
    );

    assign ref_adv = ref_en && ifc.comm_ack_i;
    comm_calib_prbs32 #(.SEED(32'h0000_0001)) u_ref (
        .i_clk (CLK),
        .i_rst (RST),
        .i_adv (ref_adv),
        .o_lfsr(ref_lfsr)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) tick <= tick + 8'd1;

    // mode 1: only (5,9) clean (bit 7 flips, outside the compared field)
    // mode 2: (2,4),(7,1) get 3 errors per 8 samples, others 5; mode 3: no valid_raw
    always_comb begin
        corrupt = '0;
        case (mode)
            1: corrupt = (ad_valid_delay == 4'd5 && ad1_delay == 4'd9) ? 8'h80 : 8'h01;
            2: if ((ad_valid_delay == 4'd2 && ad1_delay == 4'd4) ||
                   (ad_valid_delay == 4'd7 && ad1_delay == 4'd1))
                   corrupt = (tick[2:0] < 3'd3) ? 8'h01 : 8'h00;
               else
                   corrupt = (tick[2:0] < 3'd5) ? 8'h20 : 8'h00;
            default: corrupt = '0;
        endcase
    end
    assign valid_raw  = (mode != 3);
    assign raw_send_d = tick;
    assign raw_recv   = tick ^ corrupt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic start_cal();
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (done !== 1'b1 && cyc < BUDGET);
        check({tag, "_done"}, done, 1'b1);
    endtask

    task automatic check_lock(input string tag, input logic [3:0] ev, input logic [3:0] es,
                              input logic [15:0] eerr, input logic efail);
        check({tag, "_v"},    ad_valid_delay, ev);
        check({tag, "_s1"},   ad1_delay, es);
        check({tag, "_s2"},   ad2_delay, es);
        check({tag, "_err"},  best_err, eerr);
        check({tag, "_fail"}, fail, efail);
        check({tag, "_busy"}, busy, 1'b0);
        @(negedge CLK);
        check({tag, "_pulse"}, done, 1'b0);
    endtask

    initial begin
        int cyc, beats, xfers;
        RST = 1'b1; start = 1'b0;
        ifc.usr_valid_i = 0; ifc.usr_data_i = '0; ifc.usr_ack_o = 0;
        ifc.comm_ack_i = 0; ifc.comm_valid_o = 0; ifc.comm_data_o = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", busy, 0);        check("rst_done", done, 0);
        check("rst_fail", fail, 0);        check("rst_err", best_err, 0);
        check("rst_v", ad_valid_delay, 0); check("rst_s1", ad1_delay, 0);
        check("rst_s2", ad2_delay, 0);     check("rst_cvld", ifc.comm_valid_i, 0);
        check("rst_uack", ifc.usr_ack_i, 0); check("rst_uvld", ifc.usr_valid_o, 0);
        check("rst_cack", ifc.comm_ack_o, 0);
        @(posedge CLK); #1 RST = 1'b0;

        // Idle passthrough, 10 user beats with random stalls
        beats = 0; cyc = 0;
        while (beats < 10 && cyc < 200) begin
            @(posedge CLK); #1;
            cyc++;
            ifc.usr_valid_i  = ($urandom_range(0, 3) != 0);
            ifc.usr_data_i   = 32'hA500_0000 + 32'(beats * 17);
            ifc.comm_ack_i   = $urandom_range(0, 1);
            ifc.comm_valid_o = $urandom_range(0, 1);
            ifc.comm_data_o  = $urandom;
            ifc.usr_ack_o    = $urandom_range(0, 1);
            @(negedge CLK);
            check("pt_cvld", ifc.comm_valid_i, ifc.usr_valid_i);
            check("pt_cdat", ifc.comm_data_i, 32'hA500_0000 + 32'(beats * 17));
            check("pt_uack", ifc.usr_ack_i, ifc.comm_ack_i);
            check("pt_uvld", ifc.usr_valid_o, ifc.comm_valid_o);
            check("pt_udat", ifc.usr_data_o, ifc.comm_data_o);
            check("pt_cack", ifc.comm_ack_o, ifc.usr_ack_o);
            if (ifc.usr_valid_i && ifc.comm_ack_i) beats++;
        end
        check("pt_beats", beats, 10);

        // Busy: PRBS on TX, user side blocked; mode 1 optimum at (5,9)
        mode = 1;
        @(posedge CLK); #1;
        ifc.usr_valid_i = 1; ifc.usr_data_i = 32'hDEAD_BEEF; ifc.comm_valid_o = 1;
        ifc.comm_data_o = 32'h1234_5678; ifc.usr_ack_o = 0; ifc.comm_ack_i = 0;
        start = 1'b1;
        @(posedge CLK); #1 start = 1'b0; ref_en = 1'b1;
        xfers = 0;
        for (int i = 0; i < 80; i++) begin
            ifc.comm_ack_i = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
            check("bz_busy", busy, 1);
            check("bz_uack", ifc.usr_ack_i, 0);
            check("bz_uvld", ifc.usr_valid_o, 0);
            check("bz_cack", ifc.comm_ack_o, 1);
            check("bz_cvld", ifc.comm_valid_i, 1);
            check("bz_prbs", ifc.comm_data_i, ref_lfsr);
            if (xfers == 0)  check("bz_seed", ifc.comm_data_i, 32'h0000_0001);
            if (xfers == 32) check("bz_prbs32", ifc.comm_data_i, 32'h0040_0007);
            if (ifc.comm_ack_i) xfers++;
            @(posedge CLK); #1;
        end
        ref_en = 1'b0;
        check("bz_xfers", (xfers >= 33), 1);
        wait_done("s1", cyc);
        check_lock("s1", 4'd5, 4'd9, 16'h0000, 1'b0);
        @(posedge CLK); #1 ifc.usr_valid_i = 0; ifc.comm_ack_i = 1;
        @(negedge CLK);
        check("dn_cvld", ifc.comm_valid_i, 0);
        check("dn_uack", ifc.usr_ack_i, 1);
        check("dn_uvld", ifc.usr_valid_o, 1);

        // Two tied minima: first found wins
        mode = 2;
        start_cal();
        wait_done("s2", cyc);
        check_lock("s2", 4'd2, 4'd4, 16'd3, 1'b1);

        // No valid_raw: every point times out
        mode = 3;
        start_cal();
        wait_done("s3", cyc);
        check("s3_cyc", (cyc >= 256 * (T_SETTLE + T_TIMEOUT) &&
                         cyc <= 256 * (T_SETTLE + T_TIMEOUT + 4)), 1);
        check_lock("s3", 4'd0, 4'd0, 16'hFFFF, 1'b1);

        // Reset mid-MEASURE at (3,7), then restart from (0,0)
        mode = 1; ifc.usr_valid_i = 0; ifc.comm_ack_i = 0;
        start_cal();
        cyc = 0;
        while (!(ad_valid_delay == 4'd3 && ad1_delay == 4'd7) && cyc < BUDGET) begin
            @(negedge CLK);
            cyc++;
        end
        check("s5_reach", (ad_valid_delay == 4'd3 && ad1_delay == 4'd7), 1);
        repeat (T_SETTLE + 2) @(negedge CLK);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        check("s5_busy", busy, 0);        check("s5_v", ad_valid_delay, 0);
        check("s5_s1", ad1_delay, 0);     check("s5_s2", ad2_delay, 0);
        check("s5_cvld", ifc.comm_valid_i, 0); check("s5_err", best_err, 0);
        check("s5_fail", fail, 0);
        start_cal();
        cyc = 0;
        while (ad1_delay == 4'd0 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        check("s5_rs_v", ad_valid_delay, 0);
        check("s5_rs_s", ad1_delay, 1);
        wait_done("s5", cyc);
        check_lock("s5", 4'd5, 4'd9, 16'h0000, 1'b0);

        // start pulses while busy are ignored
        mode = 2;
        start_cal();
        wait_done("s6a", cyc);
        mode = 1;
        start_cal();
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
            start = (done !== 1'b1) && (cyc % 300 == 150);
        end while (done !== 1'b1 && cyc < BUDGET);
        start = 1'b0;
        check("s6_done", done, 1);
        check("s6_cyc", (cyc >= 256 * (T_SETTLE + T_NSAMP) &&
                         cyc <= 256 * (T_SETTLE + T_NSAMP + 4)), 1);
        check_lock("s6", 4'd5, 4'd9, 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/comm_delay_calib.md
Name: comm_delay_calib

Overview:
- Calibration controller and traffic arbiter for the comm link.
- On request, it sweeps ad_valid_delay and a common ad1/ad2 sample delay, drives PRBS traffic into comm, and scores each point by comparing raw_send_d with raw_recv on valid_raw.
- It then locks the best setting.
- Outside calibration it passes user traffic through transparently and holds the locked delays.

Parameters:
- NSAMP, 256: valid_raw comparisons scored per sweep point.
- SETTLE, 64: idle cycles after each delay change before scoring. Must exceed max pipeline depth (valid_delay_min+16+fifo).
- TIMEOUT, 4096: cycles allowed per point to collect NSAMP samples.
- ERRW, 16: error counter width, saturating.
- PRBS_SEED, 32'h0000_0001: LFSR seed. Must be nonzero.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- start  in  1  one-cycle calibration request
- busy  out  1  calibration in progress
- done  out  1  one-cycle pulse at end of calibration
- fail  out  1  sticky; last calibration found no zero-error point
- best_err  out  ERRW  error count of the locked point
- ad1_delay  out  4  to comm
- ad2_delay  out  4  to comm; always equals ad1_delay
- ad_valid_delay  out  4  to comm
- usr_valid_i  in  1  user TX valid
- usr_data_i  in  32  user TX data
- usr_ack_i  out  1  user TX ack
- usr_valid_o  out  1  user RX valid
- usr_data_o  out  32  user RX data
- usr_ack_o  in  1  user RX ack
- comm_valid_i  out  1  to comm.valid_i
- comm_data_i  out  32  to comm.data_i
- comm_ack_i  in  1  from comm.ack_i
- comm_valid_o  in  1  from comm.valid_o
- comm_data_o  in  32  from comm.data_o
- comm_ack_o  out  1  to comm.ack_o
- valid_raw  in  1  from comm
- raw_send_d  in  8  from comm; bits [5:0] compared
- raw_recv  in  8  from comm; bits [5:0] compared

Behaviour:
- Reset values:
  - FSM=IDLE; busy=0, done=0, fail=0, best_err=0.
  - All delay outputs 0; LFSR=PRBS_SEED.
  - comm_valid_i=0, usr_ack_i=0, usr_valid_o=0, comm_ack_o=0.
- Reset mid-calibration aborts the sweep and restores the reset values above.
- Handshakes: a transfer occurs on valid&&ack in the same cycle.
- Arbiter, IDLE/DONE:
  - comm_valid_i=usr_valid_i, comm_data_i=usr_data_i, usr_ack_i=comm_ack_i.
  - usr_valid_o=comm_valid_o, usr_data_o=comm_data_o, comm_ack_o=usr_ack_o.
  - All combinational.
- Arbiter, busy:
  - usr_ack_i=0, usr_valid_o=0, comm_ack_o=1 (RX drained and discarded).
  - comm_valid_i=1, comm_data_i=LFSR; LFSR advances on each transfer (x^32+x^22+x^2+x+1, Galois).
- Arbitration switch: start is sampled in IDLE/DONE only. The mux switches the cycle after start. A pending unacked user beat is simply withdrawn; no partial transfer is possible. start while busy is ignored.
- FSM states:
  - IDLE: start -> APPLY. Sweep indices v=0, s=0; best_err=all-ones; fail cleared.
  - APPLY: ad_valid_delay=v, ad1_delay=ad2_delay=s; clear sample/error/timeout counters -> SETTLE.
  - SETTLE: count SETTLE cycles; valid_raw ignored -> MEASURE.
  - MEASURE:
    - Each valid_raw cycle: samp++; err++ (saturating) if raw_send_d[5:0]!=raw_recv[5:0].
    - samp==NSAMP -> EVAL.
    - Timeout counter == TIMEOUT-1 -> EVAL with err forced to all-ones.
  - EVAL:
    - If err<best_err, record (v,s,err); strict compare, so the first-found point wins ties.
    - Then: s++; on s wrap, v++.
    - If v and s both wrapped (256 points done) -> LOCK; else -> APPLY.
    - Early exit: none; full sweep always.
  - LOCK: drive recorded v/s onto delay outputs; best_err=recorded err; fail=(recorded err!=0); done=1 for one cycle -> DONE.
  - DONE: behaves as IDLE; outputs held. start -> APPLY.
- busy=1 in APPLY through LOCK inclusive.
- Simultaneous events: a valid_raw arriving in the same cycle as the timeout is counted first, then the timeout applies. samp reaching NSAMP in the same cycle as the timeout -> normal EVAL with the real err.

Decomposition:
- Package comm_calib_pkg: FSM state enum, LFSR polynomial/taps constant, sweep index width (4).
- Sub-module comm_calib_prbs32: seeded Galois LFSR with advance enable. Reused by the bench as the reference model.

Test Plan:
1. Loopback model with true optimum v=5, s=9 (others corrupt raw bit 0): start -> done after full sweep; ad_valid_delay=5, ad1_delay=ad2_delay=9, best_err=0, fail=0.
2. All points corrupted, min err=3 at (2,4) and (7,1): lock (2,4) (first found), best_err=3, fail=1.
3. valid_raw never asserted: every point times out; lock (0,0), best_err=16'hFFFF, fail=1; done after ~256*(SETTLE+TIMEOUT+3) cycles.
4. User traffic: in IDLE, 10 usr beats with random comm_ack_i stalls pass through unchanged. During busy, usr_ack_i=0 and usr_valid_o=0 despite usr_valid_i=1; comm_data_i follows the PRBS sequence from the seed.
5. RST asserted at point (3,7) mid-MEASURE: next cycle busy=0, all delays 0, comm_valid_i=0. A subsequent start restarts from (0,0).
6. start pulsed while busy: ignored, sweep order and result identical to scenario 1.
